// File: rtl/wallace_pkg.sv
// Shared constants, level-count helpers and the pipeline stage record for the
// Wallace-tree multiplier (wallace_pipe_param).
package wallace_pkg;

    localparam int unsigned DefaultW = 32;

    // Rows left after one 3:2 level: every full group of 3 becomes 2
    function automatic int unsigned rows_after(input int unsigned n);
        return n - n / 3;
    endfunction

    // Row count entering carry-save level lvl+1 (lvl=0 means the partial products)
    function automatic int unsigned rows_at(input int unsigned w, input int unsigned lvl);
        int unsigned n;
        n = w;
        for (int unsigned i = 0; i < lvl; i++) begin
            n = rows_after(n);
        end
        return n;
    endfunction

    // Number of carry-save levels needed to bring rows down to two
    function automatic int unsigned num_levels(input int unsigned rows);
        int unsigned n;
        int unsigned l;
        n = rows;
        l = 0;
        while (n > 2) begin
            n = rows_after(n);
            l++;
        end
        return l;
    endfunction

    // Partial-product stage + L carry-save stages + final adder stage
    function automatic int unsigned lat_cycles(input int unsigned w);
        return num_levels(w) + 2;
    endfunction

    localparam int unsigned LAT = lat_cycles(DefaultW);

    // Per-stage control record; the row and tag payloads beside it are sized by
    // the instance parameters, so they are declared as arrays in the top level.
    typedef struct packed {
        logic valid;
        logic sgn;
    } stage_t;

endpackage

// File: rtl/csa_row.sv
// One row of full adders: compresses three N-bit rows into a sum row and a
// carry row (carry already shifted into its weight, MSB carry dropped mod 2^N).
module csa_row #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic [N-1:0] z_i,
    output logic [N-1:0] sum_o,
    output logic [N-1:0] carry_o
);

    // Bitwise 3:2 compression
    always_comb begin
        sum_o   = x_i ^ y_i ^ z_i;
        carry_o = ((x_i & y_i) | (x_i & z_i) | (y_i & z_i)) << 1;
    end

endmodule

// File: rtl/wallace_pipe_param.sv
// Pipelined Wallace-tree multiplier: registered partial products, one register
// per 3:2 level, registered final carry-propagate add. Global stall on output
// back-pressure. Optional two's-complement mode under macro MUL_SIGNED_EN.
module wallace_pipe_param
    import wallace_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned L    = num_levels(W);
    localparam int unsigned NStg = L + 2;
    localparam int unsigned PW   = 2 * W;

    logic             stall;
    logic             accept;
    logic             op_signed;

    logic [PW-1:0]    pp_d  [W];
    logic [PW-1:0]    pp_q  [W];
    logic [PW-1:0]    lvl_q [L+1][W];
    stage_t           ctl_d [NStg];
    stage_t           ctl_q [NStg];
    logic [TAG_W-1:0] tag_d [NStg];
    logic [TAG_W-1:0] tag_q [NStg];
    logic [PW-1:0]    p_d;
    logic [PW-1:0]    p_q;

    assign stall     = ctl_q[NStg-1].valid & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = ctl_q[NStg-1].valid;
    assign p         = p_q;
    assign out_tag   = tag_q[NStg-1];

`ifdef MUL_SIGNED_EN
    assign op_signed = in_signed;
`else
    logic unused_in_signed;
    assign unused_in_signed = in_signed;
    assign op_signed        = 1'b0;
`endif

    // Partial-product rows; Baugh-Wooley inverts the sign-column terms and adds
    // constants at bits W and 2W-1, placed in row slots that are otherwise empty.
    always_comb begin
        logic [W-1:0] row_bits;
        row_bits = '0;
        for (int unsigned i = 0; i < W; i++) begin
            row_bits = a & {W{b[i]}};
            if (op_signed) begin
                if (i == W - 1) begin
                    row_bits[W-2:0] = ~row_bits[W-2:0];
                end else begin
                    row_bits[W-1] = ~row_bits[W-1];
                end
            end
            pp_d[i] = accept ? ({{W{1'b0}}, row_bits} << i) : '0;
        end
        if (accept && op_signed) begin
            pp_d[0][W]      = 1'b1;
            pp_d[W-1][PW-1] = 1'b1;
        end
    end

    assign lvl_q[0] = pp_q;

    // Carry-save levels, each registered; leftover rows ride along unchanged
    for (genvar s = 1; s <= L; s++) begin : g_lvl
        localparam int NIn  = int'(rows_at(W, s - 1));
        localparam int NGrp = NIn / 3;

        logic [PW-1:0] sum_w  [NGrp];
        logic [PW-1:0] cry_w  [NGrp];
        logic [PW-1:0] rows_d [W];
        logic [PW-1:0] rows_q [W];

        for (genvar g = 0; g < NGrp; g++) begin : g_csa
            csa_row #(
                .N(PW)
            ) u_csa (
                .x_i    (lvl_q[s-1][3*g]),
                .y_i    (lvl_q[s-1][3*g+1]),
                .z_i    (lvl_q[s-1][3*g+2]),
                .sum_o  (sum_w[g]),
                .carry_o(cry_w[g])
            );
        end

        // Pack compressor outputs first, then the leftover rows
        always_comb begin
            for (int unsigned r = 0; r < W; r++) begin
                rows_d[r] = '0;
            end
            for (int g = 0; g < NGrp; g++) begin
                rows_d[2*g]   = sum_w[g];
                rows_d[2*g+1] = cry_w[g];
            end
            for (int r = 3 * NGrp; r < NIn; r++) begin
                rows_d[r-NGrp] = lvl_q[s-1][r];
            end
        end

        // Level register, frozen while the output is stalled
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rows_q <= '{default: '0};
            end else if (!stall) begin
                rows_q <= rows_d;
            end
        end

        assign lvl_q[s] = rows_q;
    end

    // Control/tag shift chain and final carry-propagate add
    always_comb begin
        ctl_d[0].valid = accept;
        ctl_d[0].sgn   = accept & op_signed;
        tag_d[0]       = accept ? in_tag : '0;
        for (int unsigned s = 1; s < NStg; s++) begin
            ctl_d[s] = ctl_q[s-1];
            tag_d[s] = tag_q[s-1];
        end
        p_d = ctl_q[L].valid ? (lvl_q[L][0] + lvl_q[L][1]) : '0;
    end

    // Partial-product, control, tag and product registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_q  <= '{default: '0};
            ctl_q <= '{default: '0};
            tag_q <= '{default: '0};
            p_q   <= '0;
        end else if (!stall) begin
            pp_q  <= pp_d;
            ctl_q <= ctl_d;
            tag_q <= tag_d;
            p_q   <= p_d;
        end
    end

endmodule

// File: doc/wallace_pipe_param.md
WALLACE_PIPE_PARAM -- requirements
Module: wallace_pipe_param

Interface
REQ-001 SHALL have parameter W, default 32, operand width in bits; legal range 4..64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operands presented.
REQ-006 SHALL have port in_ready, output, 1, pipeline accepts this cycle.
REQ-007 SHALL have port a, input, W, multiplicand.
REQ-008 SHALL have port b, input, W, multiplier.
REQ-009 SHALL have port in_signed, input, 1, two's-complement mode for this operation (used only when MUL_SIGNED_EN is defined).
REQ-010 SHALL have port in_tag, input, TAG_W, opaque tag.
REQ-011 SHALL have port out_valid, output, 1, product valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts.
REQ-013 SHALL have port p, output, 2W, product.
REQ-014 SHALL have port out_tag, output, TAG_W, tag of the product on p.

Function
REQ-015 SHALL accept an operation when in_valid and in_ready are both high at a rising clk edge.
REQ-016 SHALL generate W partial-product rows and register them in stage 0.
REQ-017 SHALL reduce rows with 3:2 carry-save levels, one register stage per level, until 2 rows remain; L = level count (W=4:2, W=8:4, W=16:6, W=32:8, W=64:10).
REQ-018 SHALL add the final two rows with a 2W-bit carry-propagate adder and register the result; total latency LAT = L+2 cycles (W=32: 10) with no stalls.
REQ-019 SHALL propagate a valid bit and the tag through every stage in lockstep with the data.
REQ-020 SHALL stall all stages (hold all registers) when out_valid=1 and out_ready=0.
REQ-021 SHALL drive in_ready = NOT(out_valid AND NOT out_ready), combinationally.
REQ-022 SHALL sustain one operation per cycle when out_ready is held high.
REQ-023 SHALL compute p = a*b mod 2^(2W) exactly, with no truncation or rounding; unsigned operands produce the full unsigned product.
REQ-024 SHALL hold p and out_tag stable while out_valid=1 and out_ready=0.
REQ-025 SHALL drive p and out_tag to 0 whenever out_valid=0.
REQ-026 SHALL never lose or duplicate an operation across any pattern of in_valid and out_ready.

Reset
REQ-027 SHALL clear all valid bits, data registers and tag registers to 0 asynchronously on rst=1.
REQ-028 SHALL drive out_valid=0, p=0, out_tag=0 and in_ready=1 during and after reset.
REQ-029 SHALL discard in-flight operations on reset asserted mid-operation; none appear after release.
REQ-030 SHALL not accept operations while rst=1.

Configuration
REQ-031 SHALL use macro MUL_SIGNED_EN.
REQ-032 SHALL, with MUL_SIGNED_EN defined, treat a and b as two's complement when in_signed=1, using Baugh-Wooley sign handling of the partial-product rows, with latency unchanged.
REQ-033 SHALL, without MUL_SIGNED_EN, ignore in_signed and produce only unsigned products.

Structure
REQ-034 SHALL place the level-count function (rows to L), the LAT constant and the stage-record typedef (rows, valid, tag, signed) in package wallace_pkg.
REQ-035 SHALL implement each carry-save level with one sub-module csa_row, a parametrised-width 3:2 compressor row; rows left over when the row count is not a multiple of 3 pass through to the next level.

Verification
REQ-036 SHALL test reset: rst pulsed mid-stream with 5 operations in flight -> out_valid=0 and p=0 during reset, and no output appears after release.
REQ-037 SHALL test max unsigned: W=32, a=b=0xFFFFFFFF, out_ready=1 -> p=0xFFFFFFFE00000001 exactly 10 cycles later.
REQ-038 SHALL test signed: MUL_SIGNED_EN defined, in_signed=1, a=0x80000000, b=0xFFFFFFFF -> p=0x0000000080000000; the same operands with in_signed=0 -> p=0x7FFFFFFF80000000.
REQ-039 SHALL test back-pressure: 20 back-to-back operations with out_ready toggled randomly -> all 20 products and tags emerge in order with none lost or duplicated, and p is stable while stalled.
REQ-040 SHALL test throughput: 100 consecutive operations with out_ready=1 -> out_valid high for 100 consecutive cycles starting at cycle LAT.
REQ-041 SHALL test the small configuration: W=4, exhaustive 256 operand pairs -> every product correct, LAT=4.
